regfile_2w2r_sync: RTL and testbench

Parametrised two-write/two-read register file for the datapath; next generation of the 8x8 latch-based two-port file. Storage is edge-triggered flops with asynchronous clear. Read data is registered, with optional same-cycle write-to-read bypass, a defined write-collision priority, an optional hardwired zero register and a collision flag.
Sits between the instruction decode/operand fetch stage (reads) and the writeback stage (writes).

---
 rtl/regfile_2w2r_sync_pkg.sv | 32 +++
 rtl/regfile_wr_arb.sv | 36 +++
 rtl/regfile_2w2r_sync.sv | 93 +++++++++
 tb/tb_regfile_2w2r_sync.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_2w2r_sync_pkg.sv
// Shared types, default widths and the collision-resolved write helper
// used by the 2-write/2-read register file.
package regfile_2w2r_sync_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 3;
    localparam int DEPTH  = 1 << AW_DEF;

    typedef struct packed {
        logic we;    // entry is written this edge
        logic sel1;  // take port 1 data (port 1 wins a collision)
    } wr_ctl_t;

    function automatic wr_ctl_t resolve_wr(
        input int unsigned idx,
        input logic        we0,
        input int unsigned waddr0,
        input logic        we1,
        input int unsigned waddr1,
        input logic        zero_reg
    );
        wr_ctl_t c;
        logic    hit0;
        logic    hit1;
        hit0   = we0 && (waddr0 == idx);
        hit1   = we1 && (waddr1 == idx);
        c.we   = (hit0 || hit1) && !(zero_reg && (idx == 0));
        c.sel1 = hit1;
        return c;
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Combinational write arbiter: per-entry write enable and data select for
// both write ports, plus the raw same-entry collision bit.
module regfile_wr_arb
    import regfile_2w2r_sync_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              i_we0,
    input  logic [AW-1:0]     i_waddr0,
    input  logic              i_we1,
    input  logic [AW-1:0]     i_waddr1,
    output logic [(1<<AW)-1:0] o_we_vec,
    output logic [(1<<AW)-1:0] o_sel1_vec,
    output logic              o_collision
);

    localparam int N_ENT = 1 << AW;

    always_comb begin
        wr_ctl_t w_ctl;
        // NOTE: every output gets a default before the loop so no latch is inferred.
        o_we_vec   = '0;
        o_sel1_vec = '0;
        for (int unsigned i = 0; i < N_ENT; i++) begin
            w_ctl = resolve_wr(i, i_we0, 32'(i_waddr0), i_we1, 32'(i_waddr1), ZERO_REG);
            o_we_vec[i]   = w_ctl.we;
            o_sel1_vec[i] = w_ctl.sel1;
        end
    end

    // A collision on the hardwired zero entry writes nothing, so it is not flagged.
    assign o_collision = i_we0 && i_we1 && (i_waddr0 == i_waddr1)
                         && !(ZERO_REG && (i_waddr0 == '0));

endmodule

// File: rtl/regfile_2w2r_sync.sv
// Two-write/two-read flop-based register file with registered read data,
// optional write-to-read bypass, optional zero register and collision flag.
module regfile_2w2r_sync
    import regfile_2w2r_sync_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we0,
    input  logic [AW-1:0] waddr0,
    input  logic [DW-1:0] wdata0,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  logic [DW-1:0] wdata1,
    input  logic          re0,
    input  logic [AW-1:0] raddr0,
    output logic [DW-1:0] rdata0,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    output logic          wr_collision
);

    localparam int N_ENT = 1 << AW;

    logic [N_ENT-1:0] w_we_vec;
    logic [N_ENT-1:0] w_sel1_vec;
    logic             w_collision;
    logic [DW-1:0]    w_rd0;
    logic [DW-1:0]    w_rd1;
    logic [DW-1:0]    r_mem [N_ENT];
    logic [DW-1:0]    r_rdata0;
    logic [DW-1:0]    r_rdata1;
    logic             r_wr_collision;

    regfile_wr_arb #(
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_wr_arb (
        .i_we0       (we0),
        .i_waddr0    (waddr0),
        .i_we1       (we1),
        .i_waddr1    (waddr1),
        .o_we_vec    (w_we_vec),
        .o_sel1_vec  (w_sel1_vec),
        .o_collision (w_collision)
    );

    // NOTE: the array is cleared by reset because every entry must read 0 afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENT; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < N_ENT; i++) begin
                // NOTE: non-blocking so every entry and read register sees pre-edge state.
                if (w_we_vec[i]) r_mem[i] <= w_sel1_vec[i] ? wdata1 : wdata0;
            end
        end
    end

    always_comb begin
        w_rd0 = r_mem[raddr0];
        if (BYPASS && w_we_vec[raddr0]) w_rd0 = w_sel1_vec[raddr0] ? wdata1 : wdata0;
        if (ZERO_REG && (raddr0 == '0)) w_rd0 = '0;
    end

    always_comb begin
        w_rd1 = r_mem[raddr1];
        if (BYPASS && w_we_vec[raddr1]) w_rd1 = w_sel1_vec[raddr1] ? wdata1 : wdata0;
        if (ZERO_REG && (raddr1 == '0)) w_rd1 = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata0       <= '0;
            r_rdata1       <= '0;
            r_wr_collision <= 1'b0;
        end else begin
            if (re0) r_rdata0 <= w_rd0;
            if (re1) r_rdata1 <= w_rd1;
            r_wr_collision <= w_collision;
        end
    end

    assign rdata0       = r_rdata0;
    assign rdata1       = r_rdata1;
    assign wr_collision = r_wr_collision;

endmodule

// File: tb/tb_regfile_2w2r_sync.sv
// Directed bench: default file (bypass, no zero reg) and a no-bypass/zero-reg
// file share stimulus; a 32x32 file checks width/depth scaling.
module tb_regfile_2w2r_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1, re0, re1;
    logic [2:0]  waddr0, waddr1, raddr0, raddr1;
    logic [7:0]  wdata0, wdata1;
    logic [7:0]  a_rdata0, a_rdata1, b_rdata0, b_rdata1;
    logic        a_coll, b_coll;

    logic        x_we0, x_we1, x_re0, x_re1;
    logic [4:0]  x_waddr0, x_waddr1, x_raddr0, x_raddr1;
    logic [31:0] x_wdata0, x_wdata1, x_rdata0, x_rdata1;
    logic        x_coll;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_2w2r_sync u_dut_a (
        .clk (clk), .rst (rst),
        .we0 (we0), .waddr0 (waddr0), .wdata0 (wdata0),
        .we1 (we1), .waddr1 (waddr1), .wdata1 (wdata1),
        .re0 (re0), .raddr0 (raddr0), .rdata0 (a_rdata0),
        .re1 (re1), .raddr1 (raddr1), .rdata1 (a_rdata1),
        .wr_collision (a_coll)
    );

    regfile_2w2r_sync #(.BYPASS(1'b0), .ZERO_REG(1'b1)) u_dut_b (
        .clk (clk), .rst (rst),
        .we0 (we0), .waddr0 (waddr0), .wdata0 (wdata0),
        .we1 (we1), .waddr1 (waddr1), .wdata1 (wdata1),
        .re0 (re0), .raddr0 (raddr0), .rdata0 (b_rdata0),
        .re1 (re1), .raddr1 (raddr1), .rdata1 (b_rdata1),
        .wr_collision (b_coll)
    );

    regfile_2w2r_sync #(.DW(32), .AW(5)) u_dut_x (
        .clk (clk), .rst (rst),
        .we0 (x_we0), .waddr0 (x_waddr0), .wdata0 (x_wdata0),
        .we1 (x_we1), .waddr1 (x_waddr1), .wdata1 (x_wdata1),
        .re0 (x_re0), .raddr0 (x_raddr0), .rdata0 (x_rdata0),
        .re1 (x_re1), .raddr1 (x_raddr1), .rdata1 (x_rdata1),
        .wr_collision (x_coll)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; re0 = 0; re1 = 0;
        waddr0 = 0; waddr1 = 0; raddr0 = 0; raddr1 = 0; wdata0 = 0; wdata1 = 0;
        x_we0 = 0; x_we1 = 0; x_re0 = 0; x_re1 = 0;
        x_waddr0 = 0; x_waddr1 = 0; x_raddr0 = 0; x_raddr1 = 0; x_wdata0 = 0; x_wdata1 = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_rd0"}, 32'(a_rdata0), 32'h0);
        check({tag, "_a_rd1"}, 32'(a_rdata1), 32'h0);
        check({tag, "_a_col"}, 32'(a_coll),   32'h0);
        check({tag, "_b_rd0"}, 32'(b_rdata0), 32'h0);
        check({tag, "_b_rd1"}, 32'(b_rdata1), 32'h0);
        check({tag, "_b_col"}, 32'(b_coll),   32'h0);
        check({tag, "_x_rd0"}, x_rdata0,      32'h0);
        check({tag, "_x_rd1"}, x_rdata1,      32'h0);
        check({tag, "_x_col"}, 32'(x_coll),   32'h0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) step();
        check_all_zero("reset");
        rst = 1'b0;

        // write A5 to entry 3, read it back, then reset mid-cycle
        we0 = 1; waddr0 = 3; wdata0 = 8'hA5;
        step();
        idle(); re0 = 1; raddr0 = 3;
        step();
        check("pre_rst_a_rd0", 32'(a_rdata0), 32'hA5);
        check("pre_rst_b_rd0", 32'(b_rdata0), 32'hA5);
        #3 rst = 1'b1;
        #1 check_all_zero("async_rst");
        idle();
        step();
        rst = 1'b0;
        re0 = 1; raddr0 = 3;
        step();
        check("post_rst_a_e3", 32'(a_rdata0), 32'h00);
        check("post_rst_b_e3", 32'(b_rdata0), 32'h00);

        // dual write to different entries, then cross read
        idle();
        we0 = 1; waddr0 = 2; wdata0 = 8'h11;
        we1 = 1; waddr1 = 5; wdata1 = 8'h22;
        x_we0 = 1; x_waddr0 = 31; x_wdata0 = 32'hDEADBEEF;
        x_we1 = 1; x_waddr1 = 1;  x_wdata1 = 32'hCAFEF00D;
        step();
        check("dual_a_col", 32'(a_coll), 32'h0);
        check("dual_x_col", 32'(x_coll), 32'h0);
        idle();
        re0 = 1; raddr0 = 5; re1 = 1; raddr1 = 2;
        x_re0 = 1; x_raddr0 = 31; x_re1 = 1; x_raddr1 = 1;
        step();
        check("cross_a_rd0", 32'(a_rdata0), 32'h22);
        check("cross_a_rd1", 32'(a_rdata1), 32'h11);
        check("cross_b_rd0", 32'(b_rdata0), 32'h22);
        check("cross_b_rd1", 32'(b_rdata1), 32'h11);
        check("wide_rd0",    x_rdata0,      32'hDEADBEEF);
        check("wide_rd1",    x_rdata1,      32'hCAFEF00D);

        // same-entry collision: port 1 wins, flag for one cycle
        idle();
        we0 = 1; waddr0 = 4; wdata0 = 8'h33;
        we1 = 1; waddr1 = 4; wdata1 = 8'h44;
        x_we0 = 1; x_waddr0 = 31; x_wdata0 = 32'h11111111;
        x_we1 = 1; x_waddr1 = 31; x_wdata1 = 32'h22222222;
        step();
        check("coll_a_flag", 32'(a_coll), 32'h1);
        check("coll_b_flag", 32'(b_coll), 32'h1);
        check("coll_x_flag", 32'(x_coll), 32'h1);
        idle();
        re0 = 1; raddr0 = 4; re1 = 1; raddr1 = 4;
        x_re0 = 1; x_raddr0 = 31;
        step();
        check("coll_a_drop", 32'(a_coll),   32'h0);
        check("coll_a_rd0",  32'(a_rdata0), 32'h44);
        check("coll_a_rd1",  32'(a_rdata1), 32'h44);
        check("coll_b_rd0",  32'(b_rdata0), 32'h44);
        check("coll_b_rd1",  32'(b_rdata1), 32'h44);
        check("coll_x_rd0",  x_rdata0,      32'h22222222);

        // bypass vs pre-write contents
        idle();
        we0 = 1; waddr0 = 6; wdata0 = 8'h01;
        step();
        we0 = 1; waddr0 = 6; wdata0 = 8'h7E; re0 = 1; raddr0 = 6;
        step();
        check("byp_a_rd0",  32'(a_rdata0), 32'h7E);
        check("byp_b_rd0",  32'(b_rdata0), 32'h01);
        check("byp_a_hold", 32'(a_rdata1), 32'h44);
        idle();
        re0 = 1; raddr0 = 6;
        step();
        check("byp_a_after", 32'(a_rdata0), 32'h7E);
        check("byp_b_after", 32'(b_rdata0), 32'h7E);

        // bypass under collision takes port 1 data on both read ports
        idle();
        we0 = 1; waddr0 = 7; wdata0 = 8'h55;
        we1 = 1; waddr1 = 7; wdata1 = 8'h66;
        re0 = 1; raddr0 = 7; re1 = 1; raddr1 = 7;
        step();
        check("bcol_a_rd0", 32'(a_rdata0), 32'h66);
        check("bcol_a_rd1", 32'(a_rdata1), 32'h66);
        check("bcol_b_rd0", 32'(b_rdata0), 32'h00);
        check("bcol_b_rd1", 32'(b_rdata1), 32'h00);
        check("bcol_b_flag", 32'(b_coll),  32'h1);
        idle();
        re0 = 1; raddr0 = 7; re1 = 1; raddr1 = 7;
        step();
        check("bcol_b_e7_0", 32'(b_rdata0), 32'h66);
        check("bcol_b_e7_1", 32'(b_rdata1), 32'h66);

        // zero register: writes discarded, no collision flag, no bypass
        idle();
        we0 = 1; waddr0 = 0; wdata0 = 8'hFF;
        we1 = 1; waddr1 = 0; wdata1 = 8'hFF;
        step();
        check("z_a_flag", 32'(a_coll), 32'h1);
        check("z_b_flag", 32'(b_coll), 32'h0);
        idle();
        re0 = 1; raddr0 = 0; re1 = 1; raddr1 = 0;
        step();
        check("z_a_rd0", 32'(a_rdata0), 32'hFF);
        check("z_a_rd1", 32'(a_rdata1), 32'hFF);
        check("z_b_rd0", 32'(b_rdata0), 32'h00);
        check("z_b_rd1", 32'(b_rdata1), 32'h00);
        idle();
        we0 = 1; waddr0 = 0; wdata0 = 8'hAA; re0 = 1; raddr0 = 0;
        step();
        check("z_a_byp", 32'(a_rdata0), 32'hAA);
        check("z_b_byp", 32'(b_rdata0), 32'h00);

        // hold: reads disabled across writes keep their outputs
        idle();
        we0 = 1; waddr0 = 2; wdata0 = 8'h3C;
        we1 = 1; waddr1 = 6; wdata1 = 8'hC3;
        step();
        check("hold_a_rd0", 32'(a_rdata0), 32'hAA);
        check("hold_a_rd1", 32'(a_rdata1), 32'hFF);
        idle();
        re1 = 1; raddr1 = 6;
        step();
        check("hold2_a_rd0", 32'(a_rdata0), 32'hAA);
        check("hold2_a_rd1", 32'(a_rdata1), 32'hC3);
        check("hold2_b_rd1", 32'(b_rdata1), 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
